// File: rtl/configPackage.sv
// rtl/configPackage.sv - shared configuration for the memory arbiter
//
// Purpose: system clock figure, default timing parameters of the memory
// arbiter, and the arbiter's state / owner enumerations.
// Ports: none (package).
package configPackage;

   // Main logic clock frequency in Hz.
   localparam int FREQ = 21_477_272;

   // Default arbiter timing.
   localparam int LATENCY_DEF          = 4;
   localparam int REFRESH_INTERVAL_DEF = 390;
   localparam int REFRESH_MAX_WAIT_DEF = 64;

   localparam int ADDR_W = 22;
   localparam int DATA_W = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } arb_state_t;

   // Which source owns the operation currently in the controller.
   typedef enum logic [2:0] {
      OWN_NONE = 3'd0,
      OWN_CPU  = 3'd1,
      OWN_PPU  = 3'd2,
      OWN_LDR  = 3'd3,
      OWN_REF  = 3'd4
   } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - three-client memory arbiter with refresh scheduling
//
// Purpose: collects one-cycle requests from the CPU, PPU and ROM loader into
// one pending slot each, issues them one at a time to the memory controller
// together with periodic refreshes, and pulses a done strobe LATENCY cycles
// after each issue.
// Ports:
//   clk, resetn                      clock, synchronous active-low reset
//   cpu_req/cpu_we/cpu_addr/cpu_din  CPU request (read or write)
//   cpu_done                         CPU completion pulse
//   ppu_req/ppu_addr, ppu_done       PPU read request and completion
//   ldr_req/ldr_addr/ldr_din         loader write request
//   ldr_done                         loader completion pulse
//   mc_read_a/mc_read_b/mc_write/mc_refresh  one-cycle issue strobes
//   mc_addr/mc_din                   issued address/data, held until next issue
//   mc_busy                          controller busy (initialising)
//   err_overrun                      sticky: request dropped, slot was full
module mem_arbiter
   import configPackage::*;
#(
   parameter int LATENCY          = LATENCY_DEF,
   parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEF,
   parameter int REFRESH_MAX_WAIT = REFRESH_MAX_WAIT_DEF
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_din,
   output logic              cpu_done,
   input  logic              ppu_req,
   input  logic [ADDR_W-1:0] ppu_addr,
   output logic              ppu_done,
   input  logic              ldr_req,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_din,
   output logic              ldr_done,
   output logic              mc_read_a,
   output logic              mc_read_b,
   output logic              mc_write,
   output logic              mc_refresh,
   output logic [ADDR_W-1:0] mc_addr,
   output logic [DATA_W-1:0] mc_din,
   input  logic              mc_busy,
   output logic              err_overrun
);

   localparam int CW = $clog2(LATENCY + 1);
   localparam int TW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
   localparam int WW = $clog2(REFRESH_MAX_WAIT + 1);

   // Client slots
   logic              r_cpu_pend;
   logic              r_cpu_we;
   logic [ADDR_W-1:0] r_cpu_addr;
   logic [DATA_W-1:0] r_cpu_din;
   logic              r_ppu_pend;
   logic [ADDR_W-1:0] r_ppu_addr;
   logic              r_ldr_pend;
   logic [ADDR_W-1:0] r_ldr_addr;
   logic [DATA_W-1:0] r_ldr_din;

   // Refresh scheduling
   logic              r_ref_pend;
   logic [TW-1:0]     r_ref_timer;
   logic [WW-1:0]     r_ref_wait;

   // Issue FSM and registered outputs
   arb_state_t        r_state;
   owner_t            r_owner;
   logic [CW-1:0]     r_cnt;
   logic              r_mc_read_a;
   logic              r_mc_read_b;
   logic              r_mc_write;
   logic              r_mc_refresh;
   logic [ADDR_W-1:0] r_mc_addr;
   logic [DATA_W-1:0] r_mc_din;
   logic              r_cpu_done;
   logic              r_ppu_done;
   logic              r_ldr_done;
   logic              r_err;

   logic              w_complete;
   logic              w_cpu_cmpl;
   logic              w_ppu_cmpl;
   logic              w_ldr_cmpl;
   logic              w_ref_wrap;
   logic              w_ref_promoted;
   logic              w_overrun;
   owner_t            w_sel;

   assign w_complete = (r_state == ST_WAIT) && (r_cnt == CW'(LATENCY));
   assign w_cpu_cmpl = w_complete && (r_owner == OWN_CPU);
   assign w_ppu_cmpl = w_complete && (r_owner == OWN_PPU);
   assign w_ldr_cmpl = w_complete && (r_owner == OWN_LDR);

   assign w_ref_wrap     = (r_ref_timer == TW'(REFRESH_INTERVAL - 1));
   assign w_ref_promoted = r_ref_pend && (r_ref_wait == WW'(REFRESH_MAX_WAIT));

   // A slot that is finishing this very cycle is free to take the new request.
   assign w_overrun = (cpu_req && r_cpu_pend && !w_cpu_cmpl) ||
                      (ppu_req && r_ppu_pend && !w_ppu_cmpl) ||
                      (ldr_req && r_ldr_pend && !w_ldr_cmpl);

   // Source selection for an issue in this cycle.
   always_comb begin
      w_sel = OWN_NONE;
      if (r_state == ST_IDLE && !mc_busy) begin
         if (w_ref_promoted)  w_sel = OWN_REF;
         else if (r_ppu_pend) w_sel = OWN_PPU;
         else if (r_cpu_pend) w_sel = OWN_CPU;
         else if (r_ldr_pend) w_sel = OWN_LDR;
         else if (r_ref_pend) w_sel = OWN_REF;
      end
   end

   // Client request slots and the sticky overrun flag.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_cpu_pend <= 1'b0;
         r_cpu_we   <= 1'b0;
         r_cpu_addr <= '0;
         r_cpu_din  <= '0;
         r_ppu_pend <= 1'b0;
         r_ppu_addr <= '0;
         r_ldr_pend <= 1'b0;
         r_ldr_addr <= '0;
         r_ldr_din  <= '0;
         r_err      <= 1'b0;
      end else begin
         if (cpu_req && (!r_cpu_pend || w_cpu_cmpl)) begin
            r_cpu_pend <= 1'b1;
            r_cpu_we   <= cpu_we;
            r_cpu_addr <= cpu_addr;
            r_cpu_din  <= cpu_din;
         end else if (w_cpu_cmpl) begin
            r_cpu_pend <= 1'b0;
         end

         if (ppu_req && (!r_ppu_pend || w_ppu_cmpl)) begin
            r_ppu_pend <= 1'b1;
            r_ppu_addr <= ppu_addr;
         end else if (w_ppu_cmpl) begin
            r_ppu_pend <= 1'b0;
         end

         if (ldr_req && (!r_ldr_pend || w_ldr_cmpl)) begin
            r_ldr_pend <= 1'b1;
            r_ldr_addr <= ldr_addr;
            r_ldr_din  <= ldr_din;
         end else if (w_ldr_cmpl) begin
            r_ldr_pend <= 1'b0;
         end

         if (w_overrun) r_err <= 1'b1;
      end
   end

   // Refresh timer, pending flag and starvation counter. A refresh has no
   // done pulse, so its pending flag is retired as soon as it is issued; a
   // wrap landing on the issue cycle re-arms it.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_ref_timer <= '0;
         r_ref_pend  <= 1'b0;
         r_ref_wait  <= '0;
      end else begin
         r_ref_timer <= w_ref_wrap ? '0 : r_ref_timer + 1'b1;

         if (w_ref_wrap)            r_ref_pend <= 1'b1;
         else if (w_sel == OWN_REF) r_ref_pend <= 1'b0;

         if (w_sel == OWN_REF)
            r_ref_wait <= '0;
         else if (r_ref_pend && r_ref_wait != WW'(REFRESH_MAX_WAIT))
            r_ref_wait <= r_ref_wait + 1'b1;
      end
   end

   // Issue / wait FSM with registered strobes.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state      <= ST_IDLE;
         r_owner      <= OWN_NONE;
         r_cnt        <= '0;
         r_mc_read_a  <= 1'b0;
         r_mc_read_b  <= 1'b0;
         r_mc_write   <= 1'b0;
         r_mc_refresh <= 1'b0;
         r_mc_addr    <= '0;
         r_mc_din     <= '0;
         r_cpu_done   <= 1'b0;
         r_ppu_done   <= 1'b0;
         r_ldr_done   <= 1'b0;
      end else begin
         r_mc_read_a  <= 1'b0;
         r_mc_read_b  <= 1'b0;
         r_mc_write   <= 1'b0;
         r_mc_refresh <= 1'b0;
         r_cpu_done   <= 1'b0;
         r_ppu_done   <= 1'b0;
         r_ldr_done   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_sel != OWN_NONE) begin
                  r_state <= ST_WAIT;
                  r_owner <= w_sel;
                  r_cnt   <= CW'(1);
                  case (w_sel)
                     OWN_PPU: begin
                        r_mc_read_b <= 1'b1;
                        r_mc_addr   <= r_ppu_addr;
                        r_mc_din    <= '0;
                     end
                     OWN_CPU: begin
                        r_mc_read_a <= !r_cpu_we;
                        r_mc_write  <= r_cpu_we;
                        r_mc_addr   <= r_cpu_addr;
                        r_mc_din    <= r_cpu_din;
                     end
                     OWN_LDR: begin
                        r_mc_write <= 1'b1;
                        r_mc_addr  <= r_ldr_addr;
                        r_mc_din   <= r_ldr_din;
                     end
                     OWN_REF: begin
                        r_mc_refresh <= 1'b1;
                        r_mc_addr    <= '0;
                        r_mc_din     <= '0;
                     end
                     default: ;
                  endcase
               end
            end
            ST_WAIT: begin
               // Done lands in the cycle the controller presents read data.
               if (w_complete) begin
                  r_state    <= ST_IDLE;
                  r_owner    <= OWN_NONE;
                  r_cpu_done <= (r_owner == OWN_CPU);
                  r_ppu_done <= (r_owner == OWN_PPU);
                  r_ldr_done <= (r_owner == OWN_LDR);
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign mc_read_a   = r_mc_read_a;
   assign mc_read_b   = r_mc_read_b;
   assign mc_write    = r_mc_write;
   assign mc_refresh  = r_mc_refresh;
   assign mc_addr     = r_mc_addr;
   assign mc_din      = r_mc_din;
   assign cpu_done    = r_cpu_done;
   assign ppu_done    = r_ppu_done;
   assign ldr_done    = r_ldr_done;
   assign err_overrun = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [21:0] cpu_addr = '0;
   logic [7:0]  cpu_din = '0;
   logic        ppu_req = 1'b0;
   logic [21:0] ppu_addr = '0;
   logic        ldr_req = 1'b0;
   logic [21:0] ldr_addr = '0;
   logic [7:0]  ldr_din = '0;
   logic        mc_busy = 1'b0;
   logic        cpu_done, ppu_done, ldr_done;
   logic        mc_read_a, mc_read_b, mc_write, mc_refresh;
   logic [21:0] mc_addr;
   logic [7:0]  mc_din;
   logic        err_overrun;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk(clk), .resetn(resetn),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_done(cpu_done),
      .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_done(ppu_done),
      .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_din(ldr_din), .ldr_done(ldr_done),
      .mc_read_a(mc_read_a), .mc_read_b(mc_read_b), .mc_write(mc_write),
      .mc_refresh(mc_refresh), .mc_addr(mc_addr), .mc_din(mc_din),
      .mc_busy(mc_busy), .err_overrun(err_overrun)
   );

   typedef struct {
      logic        creq, cwe;
      logic [21:0] caddr;
      logic [7:0]  cdin;
      logic        preq;
      logic [21:0] paddr;
      logic        lreq;
      logic [21:0] laddr;
      logic [7:0]  ldin;
      logic [3:0]  mc;    // {read_a, read_b, write, refresh}
      logic [2:0]  dn;    // {cpu, ppu, ldr}
      logic        err;
      logic [21:0] ea;
      logic [7:0]  ed;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic creq, input logic cwe, input logic [21:0] caddr,
                               input logic [7:0] cdin, input logic preq, input logic [21:0] paddr,
                               input logic lreq, input logic [21:0] laddr, input logic [7:0] ldin,
                               input logic [3:0] mc, input logic [2:0] dn, input logic err,
                               input logic [21:0] ea, input logic [7:0] ed);
      vec_t v;
      v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cdin = cdin;
      v.preq = preq; v.paddr = paddr;
      v.lreq = lreq; v.laddr = laddr; v.ldin = ldin;
      v.mc = mc; v.dn = dn; v.err = err; v.ea = ea; v.ed = ed;
      vecs.push_back(v);
   endfunction

   function automatic void idle(input int n, input logic err, input logic [21:0] ea,
                                input logic [7:0] ed);
      for (int k = 0; k < n; k++)
         add(0, 0, '0, '0, 0, '0, 0, '0, '0, 4'b0000, 3'b000, err, ea, ed);
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [37:0] outs();
      return {mc_read_a, mc_read_b, mc_write, mc_refresh, cpu_done, ppu_done, ldr_done,
              err_overrun, mc_addr, mc_din};
   endfunction

   task automatic do_reset();
      resetn = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
   endtask

   int first_ref, ref_cnt, ppu_iss, ppu_dn, b_after_ref, multi, bad;
   logic [21:0] ref_addr;

   initial begin
      // Reset state
      do_reset();
      check("reset_outputs", 64'(outs()), 64'd0);

      // Vector table: edge n of the table is row n (1-based).
      // Request on the completion cycle and on the done cycle: no overrun
      add(1,0,22'h001234,8'h00, 0,'0, 0,'0,'0, 4'b0000,3'b000,0, 22'h000000,8'h00); // 1
      add(0,0,'0,'0, 0,'0, 0,'0,'0, 4'b1000,3'b000,0, 22'h001234,8'h00);             // 2
      idle(3, 0, 22'h001234, 8'h00);                                                // 3-5
      add(1,0,22'h000020,8'h00, 0,'0, 0,'0,'0, 4'b0000,3'b100,0, 22'h001234,8'h00); // 6
      add(0,0,'0,'0, 0,'0, 0,'0,'0, 4'b1000,3'b000,0, 22'h000020,8'h00);             // 7
      idle(3, 0, 22'h000020, 8'h00);                                                // 8-10
      add(0,0,'0,'0, 0,'0, 0,'0,'0, 4'b0000,3'b100,0, 22'h000020,8'h00);             // 11
      add(1,0,22'h000030,8'h00, 0,'0, 0,'0,'0, 4'b0000,3'b000,0, 22'h000020,8'h00); // 12
      add(0,0,'0,'0, 0,'0, 0,'0,'0, 4'b1000,3'b000,0, 22'h000030,8'h00);             // 13
      idle(3, 0, 22'h000030, 8'h00);                                                // 14-16
      add(0,0,'0,'0, 0,'0, 0,'0,'0, 4'b0000,3'b100,0, 22'h000030,8'h00);             // 17
      // CPU and PPU together: PPU first, CPU five cycles later
      add(1,0,22'h000100,8'h00, 1,22'h2ABCDE, 0,'0,'0, 4'b0000,3'b000,0, 22'h000030,8'h00); // 18
      add(0,0,'0,'0, 0,'0, 0,'0,'0, 4'b0100,3'b000,0, 22'h2ABCDE,8'h00);             // 19
      idle(3, 0, 22'h2ABCDE, 8'h00);                                                // 20-22
      add(0,0,'0,'0, 0,'0, 0,'0,'0, 4'b0000,3'b010,0, 22'h2ABCDE,8'h00);             // 23
      add(0,0,'0,'0, 0,'0, 0,'0,'0, 4'b1000,3'b000,0, 22'h000100,8'h00);             // 24
      idle(3, 0, 22'h000100, 8'h00);                                                // 25-27
      add(0,0,'0,'0, 0,'0, 0,'0,'0, 4'b0000,3'b100,0, 22'h000100,8'h00);             // 28
      // CPU write beats loader write
      add(1,1,22'h000055,8'hA5, 0,'0, 1,22'h3FFFFF,8'h3C, 4'b0000,3'b000,0, 22'h000100,8'h00); // 29
      add(0,0,'0,'0, 0,'0, 0,'0,'0, 4'b0010,3'b000,0, 22'h000055,8'hA5);             // 30
      idle(3, 0, 22'h000055, 8'hA5);                                                // 31-33
      add(0,0,'0,'0, 0,'0, 0,'0,'0, 4'b0000,3'b100,0, 22'h000055,8'hA5);             // 34
      add(0,0,'0,'0, 0,'0, 0,'0,'0, 4'b0010,3'b000,0, 22'h3FFFFF,8'h3C);             // 35
      idle(3, 0, 22'h3FFFFF, 8'h3C);                                                // 36-38
      add(0,0,'0,'0, 0,'0, 0,'0,'0, 4'b0000,3'b001,0, 22'h3FFFFF,8'h3C);             // 39
      // Overrun: second CPU request while the first is in flight
      add(1,0,22'h000777,8'h00, 0,'0, 0,'0,'0, 4'b0000,3'b000,0, 22'h3FFFFF,8'h3C); // 40
      add(0,0,'0,'0, 0,'0, 0,'0,'0, 4'b1000,3'b000,0, 22'h000777,8'h00);             // 41
      add(1,0,22'h000999,8'h00, 0,'0, 0,'0,'0, 4'b0000,3'b000,1, 22'h000777,8'h00); // 42
      idle(2, 1, 22'h000777, 8'h00);                                                // 43-44
      add(0,0,'0,'0, 0,'0, 0,'0,'0, 4'b0000,3'b100,1, 22'h000777,8'h00);             // 45
      idle(4, 1, 22'h000777, 8'h00);                                                // 46-49

      for (int i = 0; i < vecs.size(); i++) begin
         cpu_req = vecs[i].creq; cpu_we = vecs[i].cwe;
         cpu_addr = vecs[i].caddr; cpu_din = vecs[i].cdin;
         ppu_req = vecs[i].preq; ppu_addr = vecs[i].paddr;
         ldr_req = vecs[i].lreq; ldr_addr = vecs[i].laddr; ldr_din = vecs[i].ldin;
         tick();
         check($sformatf("vec%0d", i + 1), 64'(outs()),
               64'({vecs[i].mc, vecs[i].dn, vecs[i].err, vecs[i].ea, vecs[i].ed}));
      end
      cpu_req = 0; cpu_we = 0; ppu_req = 0; ldr_req = 0;

      // Starved refresh: PPU kept busy, refresh pending from edge 390,
      // promoted after 64 waiting cycles, issued at the first free slot (456).
      do_reset();
      first_ref = 0; ref_cnt = 0; ppu_iss = 0; ppu_dn = 0; b_after_ref = 0; multi = 0;
      ref_addr = '1;
      for (int e = 1; e <= 480; e++) begin
         ppu_req  = (e >= 300 && e <= 455 && ((e - 300) % 5) == 0);
         ppu_addr = 22'(e);
         tick();
         if ($countones({mc_read_a, mc_read_b, mc_write, mc_refresh}) > 1) multi++;
         if (mc_refresh) begin
            ref_cnt++;
            if (first_ref == 0) begin
               first_ref = e;
               ref_addr  = mc_addr;
            end
         end
         if (mc_read_b) begin
            ppu_iss++;
            if (first_ref != 0 && b_after_ref == 0) b_after_ref = e;
         end
         if (ppu_done) ppu_dn++;
      end
      ppu_req = 0;
      check("refresh_issue_edge", 64'(first_ref), 64'd456);
      check("refresh_addr", 64'(ref_addr), 64'd0);
      check("refresh_count", 64'(ref_cnt), 64'd1);
      check("ppu_after_refresh", 64'(b_after_ref), 64'd461);
      check("ppu_issues", 64'(ppu_iss), 64'd32);
      check("ppu_dones", 64'(ppu_dn), 64'd32);
      check("strobes_onehot", 64'(multi), 64'd0);
      check("ppu_no_overrun", 64'(err_overrun), 64'd0);

      // Reset during a loader write, then controller busy after reset
      do_reset();
      ldr_req = 1; ldr_addr = 22'h012345; ldr_din = 8'h77;
      tick();
      ldr_req = 0;
      tick();
      check("ldr_issue", 64'({mc_write, mc_addr, mc_din}), 64'({1'b1, 22'h012345, 8'h77}));
      tick();
      resetn = 0; mc_busy = 1;
      tick();
      tick();
      check("reset_mid_wait", 64'(outs()), 64'd0);
      resetn = 1;
      cpu_req = 1; cpu_addr = 22'h0ABCDE; cpu_din = 8'h00;
      tick();
      cpu_req = 0;
      bad = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (mc_read_a || mc_read_b || mc_write || mc_refresh ||
             cpu_done || ppu_done || ldr_done) bad++;
      end
      check("busy_no_issue", 64'(bad), 64'd0);
      mc_busy = 0;
      tick();
      check("busy_release_issue", 64'({mc_read_a, mc_addr}), 64'({1'b1, 22'h0ABCDE}));
      repeat (3) tick();
      check("busy_cpu_not_yet", 64'(cpu_done), 64'd0);
      tick();
      check("busy_cpu_done", 64'(cpu_done), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LATENCY, default 4: cycles from an issue pulse to valid read data or write completion in the memory controller.
REQ-002 Parameter REFRESH_INTERVAL, default 390: clk cycles between refresh requests.
REQ-003 Parameter REFRESH_MAX_WAIT, default 64: cycles a pending refresh may wait before it is promoted to top priority.
REQ-004 Ports, clock and reset first; reset resetn, synchronous, active-low; clock clk:
clk  in  1  main logic clock
resetn  in  1  synchronous active-low reset
cpu_req  in  1  one-cycle request pulse from CPU
cpu_we  in  1  1=write, 0=read; sampled with cpu_req
cpu_addr  in  22  CPU byte address
cpu_din  in  8  CPU write data
cpu_done  out  1  one-cycle completion pulse
ppu_req  in  1  one-cycle read request pulse from PPU (read only)
ppu_addr  in  22  PPU byte address
ppu_done  out  1  one-cycle completion pulse
ldr_req  in  1  one-cycle write request pulse from ROM loader
ldr_addr  in  22  loader address
ldr_din  in  8  loader data
ldr_done  out  1  one-cycle completion pulse
mc_read_a  out  1  CPU read issue to controller
mc_read_b  out  1  PPU read issue to controller
mc_write  out  1  write issue
mc_refresh  out  1  refresh issue
mc_addr  out  22  issued address
mc_din  out  8  issued write data
mc_busy  in  1  controller busy
err_overrun  out  1  sticky: request arrived while same client already pending

Function
REQ-005 Each client has one pending slot; a req pulse latches addr/data/we and sets pending.
REQ-006 A req on a client whose slot is pending and not completing in that cycle is dropped and sets err_overrun.
REQ-007 A req in the same cycle as that client's done pulse is latched as a new pending request; no error.
REQ-008 States: IDLE, WAIT. Issue only from IDLE with mc_busy=0 and at least one pending source (client or refresh).
REQ-009 Priority: promoted refresh > PPU > CPU > loader > normal refresh.
REQ-010 Issue: exactly one mc_* strobe high for one cycle, registered output; mc_addr/mc_din held stable from issue until the next issue.
REQ-011 CPU read -> mc_read_a; PPU read -> mc_read_b; CPU or loader write -> mc_write; refresh -> mc_refresh with mc_addr=0.
REQ-012 On issue go to WAIT, counter=1; counter increments each cycle; when counter==LATENCY pulse owner's done (refresh: none), clear its pending, return to IDLE.
REQ-013 done coincides with the cycle the controller's dout_a/dout_b carries valid data; the client samples it there.
REQ-014 Issue the earliest one cycle after WAIT exits; a back-to-back issue period is therefore LATENCY+1 cycles minimum.
REQ-015 Refresh timer counts 0..REFRESH_INTERVAL-1, wraps, sets refresh pending at wrap; a wrap while refresh is already pending does not stack.
REQ-016 Refresh wait counter runs while refresh is pending and saturates at REFRESH_MAX_WAIT; promotion when it equals REFRESH_MAX_WAIT; cleared on refresh issue.
REQ-017 While mc_busy=1 in IDLE (controller initialising), no issue; requests still latch.

Reset
REQ-018 On resetn=0: state IDLE, all pending cleared, counters 0, all mc_* strobes, done pulses, err_overrun 0, mc_addr/mc_din 0.
REQ-019 Reset mid-WAIT abandons the operation silently; no done pulse afterwards.

Structure
REQ-020 LATENCY default, REFRESH_INTERVAL default, and state enum live in configPackage alongside FREQ.
REQ-021 Single module; no sub-modules.

Verification
REQ-022 CPU read 0x00_1234 alone -> mc_read_a one cycle later, mc_addr=0x001234, cpu_done 4 cycles after issue.
REQ-023 cpu_req and ppu_req same cycle -> PPU issued first, CPU issued 5 cycles later, both done once.
REQ-024 cpu_req twice within 3 cycles -> err_overrun=1, only one issue.
REQ-025 Refresh pending with PPU requests every 5 cycles for 100 cycles -> mc_refresh issued by wait count 64, before the next PPU.
REQ-026 resetn low 2 cycles after a loader write issue -> no ldr_done, all outputs 0; with mc_busy=1 after reset, nothing issues until mc_busy=0.
